// File: rtl/usb_tx_pkt_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_pkt_buffer_pkg                                                |
// | Shared PID codes, FSM state encoding and PID helpers.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package usb_tx_pkt_buffer_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Only DATAx PIDs may carry a payload.
  function automatic logic pid_is_data(input logic [3:0] pid);
    return pid[1:0] == 2'b11;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_pkt_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_pkt_buffer_if                                                 |
// | Producer and serializer handshake bundle of the TX packet buffer.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface usb_tx_pkt_buffer_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_full;
  logic       commit;
  logic [3:0] commit_pid;
  logic       commit_err;
  logic       abort;
  logic       busy;
  logic       pkt_start;
  logic [3:0] pid;
  logic       tx_data_avail;
  logic       tx_data_get;
  logic [7:0] tx_data;
  logic       pkt_end;
  logic       pkt_done;

  modport master (
    output wr_en, wr_data, commit, commit_pid, abort, tx_data_get, pkt_end,
    input  wr_full, commit_err, busy, pkt_start, pid, tx_data_avail, tx_data, pkt_done
  );

  modport slave (
    input  wr_en, wr_data, commit, commit_pid, abort, tx_data_get, pkt_end,
    output wr_full, commit_err, busy, pkt_start, pid, tx_data_avail, tx_data, pkt_done
  );
endinterface
`default_nettype wire

// File: rtl/usb_tx_pkt_buffer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_pkt_buffer_fifo                                               |
// | Synchronous FWFT byte FIFO with registered head, level and flush.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module usb_tx_pkt_buffer_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_aw:0]    level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             w_push_ok, w_pop_ok;

  always_comb begin
    w_push_ok = push_i && (level_q != c_depth) && !flush_i;
    w_pop_ok  = pop_i && (level_q != '0);
    wr_ptr_d  = wr_ptr_q + c_aw'(w_push_ok);
    rd_ptr_d  = rd_ptr_q + c_aw'(w_pop_ok);
    level_d   = level_q + (c_aw + 1)'(w_push_ok) - (c_aw + 1)'(w_pop_ok);
    // Head register looks ahead: a byte pushed into an otherwise empty slot becomes the head directly.
    if (level_d == '0) begin
      dout_d = '0;
    end else if (w_push_ok && (wr_ptr_q == rd_ptr_d)) begin
      dout_d = din_i;
    end else begin
      dout_d = mem_q[rd_ptr_d];
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      dout_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
    end
  end

  assign dout_o  = dout_q;
  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/usb_tx_pkt_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_tx_pkt_buffer                                                    |
// | Stages committed packets and serves them to the USB FS serializer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module usb_tx_pkt_buffer
  import usb_tx_pkt_buffer_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int MAX_PKT = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  usb_tx_pkt_buffer_if.slave        bus_io
);
  localparam int c_cw = $clog2(DEPTH) + 1;
  localparam logic [c_cw-1:0] c_depth   = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_max_pkt = c_cw'(MAX_PKT);

  state_e          state_q;
  logic [c_cw-1:0] wr_cnt_q, desc_len_q, remain_q;
  logic            desc_valid_q, pkt_start_q, pkt_done_q, commit_err_q;
  logic [3:0]      desc_pid_q, pid_q;

  logic [c_cw-1:0] w_level, w_cnt_next, w_remain_pop;
  logic [7:0]      w_head;
  logic            w_full, w_push_ok, w_pop, w_commit_bad;

  usb_tx_pkt_buffer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (bus_io.abort),
    .push_i  (bus_io.wr_en),
    .din_i   (bus_io.wr_data),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .level_o (w_level)
  );

  always_comb begin
    w_full     = (w_level == c_depth);
    w_push_ok  = bus_io.wr_en && !w_full;
    w_cnt_next = wr_cnt_q + c_cw'(w_push_ok);
    w_pop      = 1'b0;
    case (state_q)
      ST_SEND:  w_pop = bus_io.tx_data_get && (remain_q != '0);
      ST_DRAIN: w_pop = (remain_q != '0);
      default:  w_pop = 1'b0;
    endcase
    w_remain_pop = remain_q - c_cw'(w_pop);
    w_commit_bad = desc_valid_q || (w_cnt_next > c_max_pkt) ||
                   ((w_cnt_next != '0) && !pid_is_data(bus_io.commit_pid));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      wr_cnt_q     <= '0;
      desc_valid_q <= 1'b0;
      desc_pid_q   <= '0;
      desc_len_q   <= '0;
      remain_q     <= '0;
      pid_q        <= '0;
      pkt_start_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
      commit_err_q <= 1'b0;
    end else if (bus_io.abort) begin
      state_q      <= ST_IDLE;
      wr_cnt_q     <= '0;
      desc_valid_q <= 1'b0;
      desc_pid_q   <= '0;
      desc_len_q   <= '0;
      remain_q     <= '0;
      pid_q        <= '0;
      pkt_start_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
      commit_err_q <= 1'b0;
    end else begin
      pkt_start_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
      commit_err_q <= 1'b0;
      wr_cnt_q     <= w_cnt_next;
      case (state_q)
        ST_IDLE: begin
          if (desc_valid_q) begin
            pkt_start_q  <= 1'b1;
            pid_q        <= desc_pid_q;
            remain_q     <= desc_len_q;
            desc_valid_q <= 1'b0;
            state_q      <= ST_SEND;
          end
        end
        ST_SEND: begin
          remain_q <= w_remain_pop;
          if (bus_io.pkt_end) begin
            if (w_remain_pop == '0) begin
              pkt_done_q <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Unserved bytes of a truncated packet are discarded one per cycle.
          remain_q <= w_remain_pop;
          if (w_remain_pop == '0) begin
            pkt_done_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (bus_io.commit) begin
        if (w_commit_bad) begin
          commit_err_q <= 1'b1;
        end else begin
          desc_valid_q <= 1'b1;
          desc_pid_q   <= bus_io.commit_pid;
          desc_len_q   <= w_cnt_next;
          wr_cnt_q     <= '0;
        end
      end
    end
  end

  assign bus_io.wr_full       = w_full;
  assign bus_io.commit_err    = commit_err_q;
  assign bus_io.busy          = desc_valid_q || (state_q != ST_IDLE);
  assign bus_io.pkt_start     = pkt_start_q;
  assign bus_io.pid           = pid_q;
  assign bus_io.tx_data_avail = (state_q == ST_SEND) && (remain_q != '0);
  assign bus_io.tx_data       = w_head;
  assign bus_io.pkt_done      = pkt_done_q;

endmodule
`default_nettype wire
